// File: rtl/led_axi_wr_ctrl.sv
// AXI4-Lite write-channel front end for the LED peripheral.
// Takes AW and W beats in any order, or both at once, and holds the captured values.
// It then issues a one-cycle register write strobe and returns an OKAY response.
module led_axi_wr_ctrl #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,  // active-high despite the name
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    output logic                              slv_reg_wren,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   slv_wstrb
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GOT_AW = 3'd1;
    localparam logic [2:0] ST_GOT_W  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    logic [2:0]                        r_state;
    logic [2:0]                        w_state_nxt;
    logic                              r_awready;
    logic                              r_wready;
    logic                              r_bvalid;
    logic                              r_wren;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     r_awaddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
    logic                              w_aw_hs;
    logic                              w_w_hs;

    assign w_aw_hs = S_AXI_AWVALID & r_awready;
    assign w_w_hs  = S_AXI_WVALID & r_wready;

    // Next-state decode of the write transaction FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_aw_hs) begin
                    w_state_nxt = ST_GOT_AW;
                end else if (w_w_hs) begin
                    w_state_nxt = ST_GOT_W;
                end
            end
            ST_GOT_AW: if (w_w_hs)  w_state_nxt = ST_WRITE;
            ST_GOT_W:  if (w_aw_hs) w_state_nxt = ST_WRITE;
            ST_WRITE:  w_state_nxt = ST_RESP;
            ST_RESP:   if (S_AXI_BREADY) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State plus output flags registered from the next state.
    // This keeps every output free of input paths and holds the readies low during reset.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
        if (S_AXI_ARESETN) begin
            r_state   <= ST_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_wren    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GOT_W);
            r_wready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GOT_AW);
            r_bvalid  <= (w_state_nxt == ST_RESP);
            r_wren    <= (w_state_nxt == ST_WRITE);
        end
    end

    // Capture address and data/strobe on their own channel handshakes
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
        if (S_AXI_ARESETN) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign slv_reg_wren  = r_wren;
    assign axi_awaddr    = r_awaddr;
    assign slv_wdata     = r_wdata;
    assign slv_wstrb     = r_wstrb;

endmodule

// File: tb/tb_led_axi_wr_ctrl.sv
// Directed, table-driven bench for led_axi_wr_ctrl.
module tb_led_axi_wr_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        wren;
    logic [3:0]  cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_strb;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_wren_cyc = -1;
    int wren_cnt = 0;
    int b_cnt    = 0;
    int exp_wren = 0;
    int exp_b    = 0;

    led_axi_wr_ctrl #(
        .C_S_AXI_ADDR_WIDTH(4),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .slv_reg_wren (wren),
        .axi_awaddr   (cap_addr),
        .slv_wdata    (cap_data),
        .slv_wstrb    (cap_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count strobes and B handshakes, enforce minimum write spacing
    always @(negedge clk) begin
        cyc++;
        if (wren === 1'b1) begin
            wren_cnt++;
            if (last_wren_cyc >= 0) check("wren_spacing", 32'(cyc - last_wren_cyc >= 3), 32'd1);
            last_wren_cyc = cyc;
        end
        if (bvalid === 1'b1 && bready === 1'b1) b_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit is_aw);
        int n = 0;
        while ((is_aw ? awready : wready) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(is_aw ? "awready_timeout" : "wready_timeout", 32'(n < 20), 32'd1);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;    // 0: AW+W together, 1: AW first, 2: W first
        int          gap;     // idle cycles between the two beats
        int          bdelay;  // cycles BREADY is held low in RESP
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t vecs[15];

    task automatic do_write(input vec_t v);
        bready = (v.bdelay == 0);
        if (v.mode == 0) begin
            awaddr = v.addr; wdata = v.data; wstrb = v.strb;
            awvalid = 1'b1; wvalid = 1'b1;
            wait_rdy(1'b1);
            wait_rdy(1'b0);
            tick();
            awvalid = 1'b0; wvalid = 1'b0;
        end else if (v.mode == 1) begin
            awaddr = v.addr; awvalid = 1'b1;
            wait_rdy(1'b1);
            tick();
            awvalid = 1'b0;
            for (int g = 0; g < v.gap; g++) begin
                check("got_aw_awready", 32'(awready), 32'd0);
                check("got_aw_wready", 32'(wready), 32'd1);
                tick();
            end
            wdata = v.data; wstrb = v.strb; wvalid = 1'b1;
            wait_rdy(1'b0);
            tick();
            wvalid = 1'b0;
        end else begin
            wdata = v.data; wstrb = v.strb; wvalid = 1'b1;
            wait_rdy(1'b0);
            tick();
            wvalid = 1'b0;
            for (int g = 0; g < v.gap; g++) begin
                check("got_w_wready", 32'(wready), 32'd0);
                check("got_w_awready", 32'(awready), 32'd1);
                tick();
            end
            awaddr = v.addr; awvalid = 1'b1;
            wait_rdy(1'b1);
            tick();
            awvalid = 1'b0;
        end
        exp_wren++;
        // Strobe cycle: one cycle after the last handshake
        check("wren_high", 32'(wren), 32'd1);
        check("wren_addr", 32'(cap_addr), 32'(v.e_addr));
        check("wren_data", cap_data, v.e_data);
        check("wren_strb", 32'(cap_strb), 32'(v.e_strb));
        check("wren_bvalid", 32'(bvalid), 32'd0);
        tick();
        check("wren_pulse_end", 32'(wren), 32'd0);
        check("resp_bvalid", 32'(bvalid), 32'd1);
        check("resp_bresp", 32'(bresp), 32'd0);
        check("resp_readies", 32'({awready, wready}), 32'd0);
        for (int d = 0; d < v.bdelay; d++) begin
            // Offer a competing beat; it must be neither accepted nor captured
            awvalid = 1'b1; awaddr = ~v.addr;
            wvalid = 1'b1; wdata = ~v.data; wstrb = ~v.strb;
            tick();
            check("hold_bvalid", 32'(bvalid), 32'd1);
            check("hold_readies", 32'({awready, wready}), 32'd0);
            check("hold_addr", 32'(cap_addr), 32'(v.e_addr));
            check("hold_data", cap_data, v.e_data);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        exp_b++;
        tick();
        check("idle_bvalid", 32'(bvalid), 32'd0);
        check("idle_readies", 32'({awready, wready}), 32'd3);
    endtask

    task automatic reset_seq();
        int w0;
        w0 = wren_cnt;
        // Reset while in GOT_AW
        awaddr = 4'h4; awvalid = 1'b1;
        wait_rdy(1'b1);
        tick();
        awvalid = 1'b0;
        check("got_aw_entry", 32'({awready, wready}), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_aw_readies", 32'({awready, wready}), 32'd0);
        check("rst_aw_addr", 32'(cap_addr), 32'd0);
        check("rst_aw_wren", 32'(wren), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_aw_release", 32'({awready, wready}), 32'd3);
        check("rst_aw_no_wren", 32'(wren_cnt - w0), 32'd0);
        // Reset while in RESP with BREADY low
        bready = 1'b0;
        awaddr = 4'hC; wdata = 32'h55AA_33CC; wstrb = 4'h5;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_wren++;
        check("rst_b_wren", 32'(wren), 32'd1);
        tick();
        check("rst_b_bvalid_pre", 32'(bvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_b_bvalid", 32'(bvalid), 32'd0);
        check("rst_b_data", cap_data, 32'd0);
        check("rst_b_strb", 32'(cap_strb), 32'd0);
        check("rst_b_addr", 32'(cap_addr), 32'd0);
        tick();
        rst = 1'b0;
        bready = 1'b1;
        tick();
    endtask

    initial begin
        //           addr   data           strb  mode gap bd  e_addr e_data         e_strb
        vecs[0]  = '{4'h0, 32'h0000_00A5, 4'hF, 0, 0, 0, 4'h0, 32'h0000_00A5, 4'hF};
        vecs[1]  = '{4'h4, 32'h1234_5678, 4'hF, 1, 2, 0, 4'h4, 32'h1234_5678, 4'hF};
        vecs[2]  = '{4'h0, 32'h0000_00FF, 4'hF, 2, 2, 0, 4'h0, 32'h0000_00FF, 4'hF};
        vecs[3]  = '{4'h8, 32'hCAFE_BABE, 4'h3, 0, 0, 5, 4'h8, 32'hCAFE_BABE, 4'h3};
        vecs[4]  = '{4'h0, 32'h0000_00A5, 4'hF, 0, 0, 0, 4'h0, 32'h0000_00A5, 4'hF};
        vecs[5]  = '{4'h4, 32'h0000_0001, 4'h1, 0, 0, 0, 4'h4, 32'h0000_0001, 4'h1};
        vecs[6]  = '{4'h8, 32'h0000_0002, 4'h2, 1, 0, 0, 4'h8, 32'h0000_0002, 4'h2};
        vecs[7]  = '{4'hC, 32'h0000_0004, 4'h4, 2, 0, 0, 4'hC, 32'h0000_0004, 4'h4};
        vecs[8]  = '{4'h0, 32'hDEAD_BEEF, 4'h8, 0, 0, 0, 4'h0, 32'hDEAD_BEEF, 4'h8};
        vecs[9]  = '{4'h4, 32'hFFFF_FFFF, 4'hF, 2, 1, 0, 4'h4, 32'hFFFF_FFFF, 4'hF};
        vecs[10] = '{4'h8, 32'h0000_0000, 4'h0, 1, 1, 0, 4'h8, 32'h0000_0000, 4'h0};
        vecs[11] = '{4'hC, 32'h8000_0001, 4'h9, 0, 0, 0, 4'hC, 32'h8000_0001, 4'h9};
        vecs[12] = '{4'hF, 32'h5A5A_A5A5, 4'h6, 1, 0, 0, 4'hF, 32'h5A5A_A5A5, 4'h6};
        vecs[13] = '{4'h1, 32'h0BAD_F00D, 4'hC, 2, 0, 0, 4'h1, 32'h0BAD_F00D, 4'hC};
        vecs[14] = '{4'h2, 32'h1357_9BDF, 4'hA, 0, 0, 0, 4'h2, 32'h1357_9BDF, 4'hA};

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_readies", 32'({awready, wready}), 32'd0);
        check("reset_bvalid", 32'(bvalid), 32'd0);
        check("reset_bresp", 32'(bresp), 32'd0);
        check("reset_wren", 32'(wren), 32'd0);
        check("reset_capture", 32'(cap_data | 32'(cap_addr) | 32'(cap_strb)), 32'd0);
        rst = 1'b0;
        tick();
        check("post_reset_readies", 32'({awready, wready}), 32'd3);

        for (int i = 0; i < 15; i++) begin
            if (i == 4) reset_seq();
            do_write(vecs[i]);
        end

        repeat (2) tick();
        check("total_wren", 32'(wren_cnt), 32'(exp_wren));
        check("total_bresp", 32'(b_cnt), 32'(exp_b));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
